cordic_sincos_iter: RTL and testbench
=====================================

// Module: cordic_sincos_iter
// PURPOSE
//  Iterative rotation-mode CORDIC that computes cos/sin of a 32-bit binary angle.
//  It is the consumer (reader) of xita_tan_lut: it drives the LUT index i and reads back atan(2^-i) on xita.
//  Sits between the phase accumulator / control logic and the datapath that needs sin/cos.
//  Uses two cycles per micro-rotation: LUT address, then rotate.
// PARAMETERS
//  ITER    16     number of micro-rotations, 1..32 (LUT index is 5 bits)
//  DW      16     width of cos/sin outputs; signed, 1.0 = 2^(DW-2)
//  GW      2      guard bits carried in the internal x/y registers
//  X_INIT  9949   CORDIC gain-compensated start value (0.607253 * 2^(DW-2)); set for DW=16
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    request; sampled only in IDLE
//  angle      in   32   signed binary angle; 2^31 = 180 deg; range [-180,180)
//  busy       out  1    high while a computation is in progress
//  done       out  1    one-cycle pulse when cos_o/sin_o are updated
//  cos_o      out  DW   signed cosine result, held until the next done
//  sin_o      out  DW   signed sine result, held until the next done
//  lut_i      out  5    index to xita_tan_lut.i
//  lut_xita   in   32   xita_tan_lut.xita; atan(2^-i) in the same binary-angle format; 1 clk latency
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; busy=0, done=0, cos_o=0, sin_o=0, lut_i=0; all internal registers cleared.
//   - Reset mid-computation aborts the computation. No done pulse is produced.
//  FSM: IDLE -> LOAD -> (REQ -> ROT) x ITER -> OUT -> IDLE
//   - IDLE: start=1 latches angle; next state LOAD. start while busy=1 is ignored (not queued).
//   - LOAD: quadrant fold. flip = angle[31]^angle[30] (|angle| >= 90 deg).
//       z = flip ? angle ^ 32'h8000_0000 : angle
//       x = X_INIT << GW, y = 0, k = 0
//   - REQ: lut_i = k; LUT output is valid in the next cycle.
//   - ROT: d = (z >= 0) ? +1 : -1 (z is signed).
//       x' = x - d*(y>>>k), y' = y + d*(x>>>k), z' = z - d*lut_xita
//       k == ITER-1 -> OUT, else k = k+1 -> REQ
//   - OUT: cos_o = (flip ? -x : x) >>> GW; sin_o = (flip ? -y : y) >>> GW; done=1 for this cycle only.
//  Arithmetic
//   - x/y are DW+GW signed; >>> is arithmetic; z is 32-bit two's complement and wraps naturally.
//   - |result| <= 1.0004 * 2^(DW-2), so no saturation is needed.
//  Timing
//   - busy rises the cycle after start is sampled and falls together with done.
//   - done is asserted 2*ITER+2 cycles after the start edge: 34 cycles for ITER=16.
//   - Back-to-back operation: start may be asserted in the same cycle done is high.
//     It is sampled in the following IDLE cycle.
//  Edge angles
//   - +90 deg (0x4000_0000) folds to -90 deg; -180 deg (0x8000_0000) folds to 0.
//   - Both converge, because the CORDIC range is +/-99.88 deg.
// CONFIGURATION
//  CORDIC_ROUND_EN defined
//   - Every shift >>>k with k>0 adds 1<<(k-1) before shifting (round half up).
//   - The OUT-stage >>>GW rounds the same way.
//  CORDIC_ROUND_EN undefined
//   - Plain truncating arithmetic shifts.
//  Interface and latency are identical in both builds.
// TESTING  (DW=16, ITER=16, 1.0=16384, tolerance +/-4 LSB unless stated)
//  1. angle=0 -> cos_o=16384, sin_o=0; done exactly 34 clks after start; busy high for 34 clks.
//  2. angle=32'h2000_0000 (45 deg) -> cos_o=sin_o=11585.
//  3. angle=32'h4000_0000 (+90) -> cos_o=0, sin_o=16384.
//     angle=32'hC000_0000 (-90) -> sin_o=-16384.
//  4. angle=32'h8000_0000 (-180) -> cos_o=-16384, sin_o=0.
//     angle=32'hD555_5555 (-60 deg) -> cos_o=8192, sin_o=-14189.
//  5. Protocol checks:
//     - start pulsed mid-run -> ignored, result of the first angle only, one done pulse.
//     - rst_n=0 at cycle 10 of a run -> busy=0, outputs=0, no done.
//     - lut_i sequence is 0..15, each value held for the REQ+ROT pair.
//  6. Build with CORDIC_ROUND_EN -> same latency; 45 deg result within +/-2 LSB of 11585.

Source files
------------

// File: rtl/cordic_sincos_iter_if.sv
// cordic_sincos_iter_if: request/result handshake and atan LUT port of the iterative CORDIC.
interface cordic_sincos_iter_if #(
    parameter int DW = 16
);
    logic                 start;
    logic [31:0]          angle;
    logic                 busy;
    logic                 done;
    logic signed [DW-1:0] cos_o;
    logic signed [DW-1:0] sin_o;
    logic [4:0]           lut_i;
    logic [31:0]          lut_xita;
    modport master (output start, angle, lut_xita, input busy, done, cos_o, sin_o, lut_i);
    modport slave  (input start, angle, lut_xita, output busy, done, cos_o, sin_o, lut_i);
endinterface

// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative rotation-mode CORDIC sin/cos, two cycles per micro-rotation.
// Define CORDIC_ROUND_EN for round-half-up shifts instead of truncation.
module cordic_sincos_iter #(
    parameter int ITER   = 16,
    parameter int DW     = 16,
    parameter int GW     = 2,
    parameter int X_INIT = 9949
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_sincos_iter_if.slave  bus
);
    localparam int W = DW + GW;
    localparam logic signed [W-1:0] X0 = W'(X_INIT << GW);
    localparam logic [4:0] K_LAST = 5'(ITER - 1);
    typedef enum logic [2:0] {IDLE, LOAD, REQ, ROT, OUT} state_t;
    state_t              state;
    logic signed [W-1:0] x, y, xs, ys;
    logic signed [31:0]  z;
    logic [4:0]          k;
    logic                flip;
    function automatic logic signed [W-1:0] asr(input logic signed [W-1:0] v, input int s);
`ifdef CORDIC_ROUND_EN
        logic signed [W-1:0] b;
        b = s > 0 ? W'(1) << (s - 1) : '0;
        return (v + b) >>> s;
`else
        return v >>> s;
`endif
    endfunction
    assign bus.lut_i = k;
    always_comb begin
        xs = asr(x, int'(k));
        ys = asr(y, int'(k));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            k         <= '0;
            flip      <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.cos_o <= '0;
            bus.sin_o <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    z        <= bus.angle;
                    bus.busy <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    // |angle| >= 90 deg: rotate by 180 deg into CORDIC range, negate at the end
                    flip  <= z[31] ^ z[30];
                    z     <= (z[31] ^ z[30]) ? z ^ 32'h8000_0000 : z;
                    x     <= X0;
                    y     <= '0;
                    k     <= '0;
                    state <= REQ;
                end
                REQ: state <= ROT;
                ROT: begin
                    x     <= z[31] ? x + ys : x - ys;
                    y     <= z[31] ? y - xs : y + xs;
                    z     <= z[31] ? z + $signed(bus.lut_xita) : z - $signed(bus.lut_xita);
                    k     <= (k == K_LAST) ? k : k + 5'd1;
                    state <= (k == K_LAST) ? OUT : REQ;
                end
                OUT: begin
                    bus.cos_o <= DW'(asr(flip ? -x : x, GW));
                    bus.sin_o <= DW'(asr(flip ? -y : y, GW));
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sincos_iter.sv
// tb_cordic_sincos_iter: randomized and directed checks of cordic_sincos_iter against real-valued sin/cos.
module tb_cordic_sincos_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] tbl [32];
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    cordic_sincos_iter_if #(.DW(16)) bus ();
    cordic_sincos_iter #(.ITER(16), .DW(16), .GW(2), .X_INIT(9949)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    // atan(2^-i) lookup with one clock of latency
    always @(posedge clk) bus.lut_xita <= tbl[bus.lut_i];
    task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
        n_chk++;
        if (got >= exp - tol && got <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
    endtask
    function automatic void ref_cs(input logic [31:0] a, output longint c, output longint s);
        real th;
        th = $itor($signed(a)) * 3.14159265358979 / 2147483648.0;
        c = longint'($cos(th) * 16384.0);
        s = longint'($sin(th) * 16384.0);
    endfunction
    task automatic run(input logic [31:0] a, input int mid, output longint c, output longint s,
                       output int lat, output int bsy, output int lbad);
        bus.start = 1'b1;
        bus.angle = a;
        lat = -1;
        bsy = 0;
        lbad = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bsy += int'(bus.busy);
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            if (n == mid) begin
                bus.start = 1'b1;
                bus.angle = a ^ 32'h4000_0000;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bsy += int'(bus.busy);
            if (bus.done) lat = n;
            if (n <= 32 && bus.lut_i != 5'((n - 1) / 2)) lbad++;
        end
        c = bus.cos_o;
        s = bus.sin_o;
    endtask
    task automatic quiet(input int n, output int dn, output int bs);
        dn = 0;
        bs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dn += int'(bus.done);
            bs += int'(bus.busy);
        end
    endtask
    typedef struct { logic [31:0] a; int c; int s; string tag; } vec_t;
    vec_t dir [6] = '{
        '{32'h0000_0000, 16384,      0, "a0"},
        '{32'h2000_0000, 11585,  11585, "a45"},
        '{32'h4000_0000,     0,  16384, "a90"},
        '{32'hC000_0000,     0, -16384, "am90"},
        '{32'h8000_0000,-16384,      0, "am180"},
        '{32'hD555_5555,  8192, -14189, "am60"}
    };
    initial begin
        longint c, s, ec, es;
        int lat, bsy, lbad, dn, bs;
        for (int i = 0; i < 32; i++)
            tbl[i] = 32'($rtoi($atan(1.0 / (2.0 ** i)) / 3.14159265358979 * 2147483648.0 + 0.5));
        bus.start = 1'b0;
        bus.angle = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cos", bus.cos_o, 0);
        check("rst_sin", bus.sin_o, 0);
        check("rst_lut_i", bus.lut_i, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (dir[i]) begin
            run(dir[i].a, 0, c, s, lat, bsy, lbad);
            check({dir[i].tag, "_cos"}, c, dir[i].c, 4);
            check({dir[i].tag, "_sin"}, s, dir[i].s, 4);
            check({dir[i].tag, "_lat"}, lat, 34);
            check({dir[i].tag, "_busy"}, bsy, 34);
            check({dir[i].tag, "_lut_seq"}, lbad, 0);
        end
        run(32'h1555_5555, 10, c, s, lat, bsy, lbad);
        check("mid_start_cos", c, 14189, 4);
        check("mid_start_sin", s, 8192, 4);
        check("mid_start_lat", lat, 34);
        quiet(40, dn, bs);
        check("mid_start_extra_done", dn, 0);
        bus.start = 1'b1;
        bus.angle = 32'h2000_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_cos", bus.cos_o, 0);
        check("abort_sin", bus.sin_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(40, dn, bs);
        check("abort_no_done", dn, 0);
        check("abort_no_busy", bs, 0);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = $urandom;
            ref_cs(a, ec, es);
            run(a, 0, c, s, lat, bsy, lbad);
            check($sformatf("rnd%0d_cos_%h", i, a), c, ec, 4);
            check($sformatf("rnd%0d_sin_%h", i, a), s, es, 4);
            check($sformatf("rnd%0d_lat", i), lat, 34);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
